arf_wb_arbiter: RTL and testbench
=================================

Name: arf_wb_arbiter

Overview:
- Shares the single write port of the 32x32 architectural register file between NREQ writeback sources (e.g. ALU, MUL, LSU).
- Uses rotating-priority (round-robin) arbitration with a valid/ready handshake per requester.
- Registers the winner onto the ARF write port (regwrite, writereg, writedata).
- Keeps a per-requester starvation counter and a global stall input so the pipeline can freeze writeback.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- DW, 32, data width.
- AW, 5, register index width.
- STARVE_MAX, 7, wait cycles after which a requester is forced to top priority.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  when 1, no grant this cycle.
- req_valid  input  NREQ  requester i has a write pending.
- req_reg  input  NREQ*AW  destination index, slice i = [i*AW +: AW].
- req_data  input  NREQ*DW  write data, slice i = [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- regwrite  output  1  ARF write enable.
- writereg  output  AW  ARF write index.
- writedata  output  DW  ARF write data.
- grant_id  output  3  index of the requester that produced the current regwrite.
- starved  output  NREQ  requester i has waited at least STARVE_MAX cycles.

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - regwrite=0, writereg=0, writedata=0, grant_id=0.
  - Round-robin pointer rr_ptr=0, all wait counters=0, starved=0.
  - req_ready is combinational and forced 0 while rst=1.
- req_ready (combinational):
  - All zero if stall=1 or rst=1.
  - Otherwise at most one bit set, chosen among valid requesters in this order:
    - (a) Starved requesters (wait_cnt >= STARVE_MAX), lowest index first.
    - (b) Otherwise the first valid index scanning from rr_ptr upward, wrapping modulo NREQ.
  - req_ready never depends on req_data or req_reg.
- Transfer: on the edge where req_valid[g] & req_ready[g]:
  - regwrite<=1, writereg<=req_reg[g], writedata<=req_data[g], grant_id<=g.
  - rr_ptr<=(g+1) mod NREQ, with explicit wrap at NREQ-1 so non-power-of-2 NREQ is handled.
- No transfer on an edge: regwrite<=0; writereg, writedata and grant_id hold.
- Latency:
  - Exactly 1 cycle from handshake to regwrite.
  - The ARF write lands on the following edge.
  - Throughput is 1 write per cycle.
- Wait counters, per i:
  - Saturating increment while req_valid[i] & ~req_ready[i] & ~stall.
  - Cleared on grant to i or when req_valid[i]=0.
  - Hold during stall.
  - starved[i] = (wait_cnt[i] >= STARVE_MAX).
- Requester obligations (not checked):
  - Once req_valid is high it stays high, with stable reg/data, until accepted.
  - Ordering between two requesters targeting the same register is the issue stage's responsibility. The arbiter does no register compare.
- Boundary conditions:
  - No requester valid: req_ready=0, regwrite=0 next cycle, rr_ptr unchanged.
  - Single valid requester: granted immediately regardless of rr_ptr.
  - All NREQ valid continuously: grants rotate 0,1,..,NREQ-1,0,…
  - stall asserted: regwrite=0 on the next edge. An already-registered write still occurs on the current cycle.
  - rst mid-transfer: pending regwrite is dropped (regwrite=0 after the reset edge) and requesters must re-present.
  - Multiple starved requesters: lowest index wins; the others keep counting.

Optional Feature:
- Macro: ARF_WB_ZERO_DROP_EN.
- Defined:
  - A granted request with req_reg==0 is accepted (req_ready asserted, rr_ptr and counter updated as normal).
  - regwrite stays 0 for that cycle, so register 0 is never written.
- Not defined: writes to index 0 are passed to the ARF like any other index.

Test Plan:
- rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, regwrite=0, writereg=0, writedata=0 throughout; first grant after release goes to requester 0.
- Only requester 1 valid, reg=5, data=0xDEADBEEF -> req_ready=3'b010 the same cycle; next cycle regwrite=1, writereg=5, writedata=0xDEADBEEF, grant_id=1.
- All 3 valid for 6 cycles -> grant_id sequence 0,1,2,0,1,2; regwrite=1 every cycle.
- Requesters 0 and 1 always valid, then requester 2 valid with STARVE_MAX=2 -> requester 2 is granted within 2 cycles, its starved bit clears after grant, and the rotation resumes at 0.
- stall=1 for 3 cycles with requester 0 valid -> req_ready=0, regwrite=0 from the cycle after stall rises; wait counters hold; grant occurs on the first cycle with stall=0.
- With ARF_WB_ZERO_DROP_EN, requester 0 writes reg 0, data 0x1234 -> req_ready[0]=1, next cycle regwrite=0. Without the macro -> regwrite=1, writereg=0.

Source files
------------

// File: rtl/arf_wb_arbiter_if.sv
// Writeback bus between the execution units and the ARF write-port arbiter.
// master = requester side (with stall), slave = arbiter side.
interface arf_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_reg;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 regwrite;
    logic [AW-1:0]        writereg;
    logic [DW-1:0]        writedata;
    logic [2:0]           grant_id;
    logic [NREQ-1:0]      starved;

    modport master (
        output stall, req_valid, req_reg, req_data,
        input  req_ready, regwrite, writereg, writedata, grant_id, starved
    );

    modport slave (
        input  stall, req_valid, req_reg, req_data,
        output req_ready, regwrite, writereg, writedata, grant_id, starved
    );
endinterface

// File: rtl/arf_wb_arbiter.sv
// Round-robin arbiter for the ARF write port with starvation override; optional ARF_WB_ZERO_DROP_EN drops writes to r0.
// Latency: 1 cycle from handshake to regwrite; one write per cycle.
// Backpressure: req_ready is one-hot and combinational, forced low by stall or rst.
module arf_wb_arbiter #(
    parameter int NREQ       = 3,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 7
) (
    input logic             clk,
    input logic             rst,
    arf_wb_arbiter_if.slave bus
);
    localparam int            CW    = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX  = CW'(STARVE_MAX);
    localparam logic [2:0]    LAST  = 3'(NREQ - 1);
    localparam logic [3:0]    NREQ4 = 4'(NREQ);

    logic [CW-1:0]   wait_cnt [NREQ];
    logic [2:0]      rr_ptr;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] starved_v;
    logic            found;
    logic [3:0]      idx;
    logic [2:0]      grant_idx;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_data;

    for (genvar i = 0; i < NREQ; i++) begin : g_starve
        assign starved_v[i] = (wait_cnt[i] >= SMAX);
    end

    assign bus.starved   = starved_v;
    assign bus.req_ready = grant;

    // Starved requesters win first (lowest index), else scan from rr_ptr with wrap.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (!rst && !bus.stall) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req_valid[i] && starved_v[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, rr_ptr} + 4'(k);
                if (idx >= NREQ4) idx = idx - NREQ4;
                for (int j = 0; j < NREQ; j++) begin
                    if (!found && (4'(j) == idx) && bus.req_valid[j]) begin
                        grant[j] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        sel_reg   = '0;
        sel_data  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                grant_idx = 3'(j);
                sel_reg   = bus.req_reg[j*AW +: AW];
                sel_data  = bus.req_data[j*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.regwrite  <= 1'b0;
            bus.writereg  <= '0;
            bus.writedata <= '0;
            bus.grant_id  <= '0;
            rr_ptr        <= '0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
        end else begin
            if (|grant) begin
`ifdef ARF_WB_ZERO_DROP_EN
                bus.regwrite <= (sel_reg != '0);
`else
                bus.regwrite <= 1'b1;
`endif
                bus.writereg  <= sel_reg;
                bus.writedata <= sel_data;
                bus.grant_id  <= grant_idx;
                rr_ptr        <= (grant_idx == LAST) ? 3'd0 : grant_idx + 3'd1;
            end else begin
                bus.regwrite <= 1'b0;
            end
            // Counters hold through stall and saturate at STARVE_MAX.
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || grant[i])
                    wait_cnt[i] <= '0;
                else if (!bus.stall && (wait_cnt[i] != SMAX))
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_arf_wb_arbiter.sv
// Directed then randomized bench for arf_wb_arbiter against a rule-level reference model.
module tb_arf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SM   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arf_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    arf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [NREQ-1:0] valid;
    logic [AW-1:0]   rreg [NREQ];
    logic [DW-1:0]   rdat [NREQ];
    bit              persist [NREQ];
    bit              allow_zero;
    logic            stall_i;

    int              m_rr;
    int              m_wait [NREQ];
    logic            m_regwrite;
    logic [AW-1:0]   m_writereg;
    logic [DW-1:0]   m_writedata;
    logic [2:0]      m_gid;

    logic [NREQ-1:0] last_ready;
    int              last_g;
    int              n;
    int              seq [6] = '{0, 1, 2, 0, 1, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (rst || stall_i) return -1;
        for (int i = 0; i < NREQ; i++)
            if (valid[i] && m_wait[i] >= SM) return i;
        for (int k = 0; k < NREQ; k++)
            if (valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    task automatic new_req(input int i);
        rreg[i] = AW'($urandom_range(allow_zero ? 0 : 1, 31));
        if (allow_zero && $urandom_range(0, 3) == 0) rreg[i] = '0;
        rdat[i]  = $urandom;
        valid[i] = 1'b1;
    endtask

    // One clock: drive, check comb outputs, take the edge, check registered outputs.
    task automatic cycle();
        int              g;
        logic [NREQ-1:0] e_rdy;
        logic [NREQ-1:0] e_stv;
        bus.stall     = stall_i;
        bus.req_valid = valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_reg[i*AW +: AW]  = rreg[i];
            bus.req_data[i*DW +: DW] = rdat[i];
        end
        #1;
        g     = model_grant();
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        for (int i = 0; i < NREQ; i++) e_stv[i] = (m_wait[i] >= SM);
        chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));
        chk("starved", 64'(bus.starved), 64'(e_stv));
        last_ready = bus.req_ready;
        last_g     = g;
        @(posedge clk);
        if (rst) begin
            m_rr = 0; m_regwrite = 1'b0; m_writereg = '0; m_writedata = '0; m_gid = '0;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
        end else begin
            if (g >= 0) begin
`ifdef ARF_WB_ZERO_DROP_EN
                m_regwrite = (rreg[g] != '0);
`else
                m_regwrite = 1'b1;
`endif
                m_writereg  = rreg[g];
                m_writedata = rdat[g];
                m_gid       = 3'(g);
                m_rr        = (g + 1) % NREQ;
            end else begin
                m_regwrite = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!valid[i] || i == g) m_wait[i] = 0;
                else if (!stall_i && m_wait[i] < SM) m_wait[i] = m_wait[i] + 1;
            end
        end
        #1;
        chk("regwrite", 64'(bus.regwrite), 64'(m_regwrite));
        chk("writereg", 64'(bus.writereg), 64'(m_writereg));
        chk("writedata", 64'(bus.writedata), 64'(m_writedata));
        chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
        if (g >= 0 && !rst) begin
            if (persist[g]) new_req(g);
            else valid[g] = 1'b0;
        end
    endtask

    initial begin
        allow_zero = 1'b0;
        stall_i    = 1'b0;
        valid      = '0;
        for (int i = 0; i < NREQ; i++) begin
            persist[i] = 1'b1;
            new_req(i);
            m_wait[i] = 0;
        end
        m_rr = 0; m_regwrite = 1'b0; m_writereg = '0; m_writedata = '0; m_gid = '0;
        bus.stall = 1'b0; bus.req_valid = '0; bus.req_reg = '0; bus.req_data = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles with everyone requesting.
        repeat (2) begin
            cycle();
            chk("rst_ready", 64'(last_ready), 64'd0);
            chk("rst_regwrite", 64'(bus.regwrite), 64'd0);
        end
        rst = 1'b0;
        cycle();
        chk("first_grant", 64'(last_ready), 64'b001);

        // Idle: nothing valid.
        for (int i = 0; i < NREQ; i++) persist[i] = 1'b0;
        valid = '0;
        repeat (2) cycle();
        chk("idle_ready", 64'(last_ready), 64'd0);
        chk("idle_regwrite", 64'(bus.regwrite), 64'd0);

        // Single requester 1.
        rreg[1] = 5'd5; rdat[1] = 32'hDEADBEEF; valid[1] = 1'b1;
        cycle();
        chk("single_ready", 64'(last_ready), 64'b010);
        chk("single_regwrite", 64'(bus.regwrite), 64'd1);
        chk("single_writereg", 64'(bus.writereg), 64'd5);
        chk("single_writedata", 64'(bus.writedata), 64'hDEADBEEF);
        chk("single_grant_id", 64'(bus.grant_id), 64'd1);

        // Bring the pointer back to 0, then full load rotation.
        new_req(2);
        cycle();
        for (int i = 0; i < NREQ; i++) begin persist[i] = 1'b1; new_req(i); end
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("rotate_grant", 64'(bus.grant_id), 64'(seq[c]));
            chk("rotate_regwrite", 64'(bus.regwrite), 64'd1);
        end
        for (int i = 0; i < NREQ; i++) persist[i] = 1'b0;
        valid = '0;
        cycle();

        // Requesters 0/1 saturate, then 2 arrives.
        persist[0] = 1'b1; persist[1] = 1'b1;
        new_req(0); new_req(1);
        repeat (3) cycle();
        new_req(2);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            n++;
            if (last_g == 2) break;
        end
        chk("starve_within2", 64'(n <= 2), 64'd1);
        cycle();
        chk("resume_at_0", 64'(bus.grant_id), 64'd0);
        chk("starved2_clear", 64'(bus.starved[2]), 64'd0);
        persist[0] = 1'b0; persist[1] = 1'b0;
        valid = '0;
        cycle();

        // Stall with requester 0 pending.
        new_req(0);
        stall_i = 1'b1;
        repeat (3) begin
            cycle();
            chk("stall_ready", 64'(last_ready), 64'd0);
            chk("stall_regwrite", 64'(bus.regwrite), 64'd0);
        end
        stall_i = 1'b0;
        cycle();
        chk("unstall_ready", 64'(last_ready), 64'b001);
        chk("unstall_regwrite", 64'(bus.regwrite), 64'd1);

        // Write to r0.
        rreg[0] = '0; rdat[0] = 32'h1234; valid[0] = 1'b1;
        cycle();
        chk("zero_ready", 64'(last_ready), 64'b001);
`ifdef ARF_WB_ZERO_DROP_EN
        chk("zero_regwrite", 64'(bus.regwrite), 64'd0);
`else
        chk("zero_regwrite", 64'(bus.regwrite), 64'd1);
        chk("zero_writereg", 64'(bus.writereg), 64'd0);
`endif

        // Reset while a write is registered.
        new_req(1);
        cycle();
        new_req(2);
        rst = 1'b1;
        cycle();
        chk("rst_mid_regwrite", 64'(bus.regwrite), 64'd0);
        rst = 1'b0;
        cycle();
        chk("rst_mid_represent", 64'(bus.grant_id), 64'd2);

        // Randomized traffic with stalls and occasional resets.
        allow_zero = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0)
                for (int i = 0; i < NREQ; i++) persist[i] = ($urandom_range(0, 1) == 1);
            rst     = ($urandom_range(0, 49) == 0);
            stall_i = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NREQ; i++)
                if (!valid[i] && $urandom_range(0, 1) == 1) new_req(i);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
